hc_mmio_rd_responder: RTL and testbench
=======================================

Name: hc_mmio_rd_responder

Overview:
- CCI-P MMIO read responder for the Reed-Solomon decoder AFU: the host-read counterpart of the existing MMIO write decode (control, DSM, buffer registers).
- Accepts host MMIO read requests on c0 Rx and returns the AFU DFH, the AFU ID, write-side register shadows and decoder status on c2 Tx.
- Sits beside the write-side CSR logic in the AFU top and drives af2cp_sTx.c2 exclusively.

Parameters:
- N_BUFFERS, default HC_BUFFER_SIZE (3): number of buffer descriptors exposed; legal range 1..6.
- AFU_ID, default 128'h0 (set per build): value returned at AFU_ID_L/AFU_ID_H.

Ports:
- pClk  in  1  AFU clock.
- pck_cp2af_softReset  in  1  synchronous, active-high reset.
- cp2af_sRx_c0  in  t_if_ccip_c0_Rx  host MMIO requests; only mmioRdValid is acted on, plus mmioWrValid when the optional feature is compiled in.
- af2cp_sTx_c2  out  t_if_ccip_c2_Tx  MMIO read response: mmioRdValid, hdr.tid, data[63:0].
- i_dsm_base  in  64  current DSM base register.
- i_control  in  32  current t_hc_control.
- i_buffer  in  N_BUFFERS x t_hc_buffer  current buffer descriptors.
- i_status  in  64  decoder status word; bit0 = done.
- i_rd_lines  in  32  count of lines fetched.
- i_wr_lines  in  32  count of lines written.

Behaviour:
- Address handling: hdr.address is a DW (4-byte) address. A request with address >= 'h400 is ignored and produces no response. Qword index = address[15:1].
- Byte map, 64-bit registers:
  - 0x000 DFH = 64'h1000_0100_0000_0000 (AFU type, end-of-list).
  - 0x008 AFU_ID[63:0]; 0x010 AFU_ID[127:64]; 0x018 and 0x020 read 0.
  - 0x110 i_dsm_base; 0x118 {32'h0, i_control}.
  - 0x120 + 0x10*k: i_buffer[k].address. 0x128 + 0x10*k: {32'h0, i_buffer[k].size}, for k < N_BUFFERS.
  - 0x180 i_status; 0x188 {32'h0, i_rd_lines}; 0x190 {32'h0, i_wr_lines}.
  - Any other address < 0x1000 reads 64'h0. It is still answered.
- Length: hdr.length 0 (4 B) returns the selected DW in data[31:0], with data[63:32] = 0. address[0] selects the upper DW. Length 1 (8 B) returns the full qword; address[0] is ignored.
- Pipeline: two register stages.
  - S1 latches {valid, tid, qword index, length, dw_sel}.
  - S2 muxes data, registers the response and asserts c2.mmioRdValid.
  - A request accepted at cycle N responds at cycle N+2 with the same tid.
  - The pipeline accepts one request per cycle, so back-to-back reads produce back-to-back responses in order.
- Data timing: the data mux samples i_* at the S1->S2 transition, i.e. the value present at cycle N+1.
- No backpressure: c2 has no almost-full, so responses are never stalled or dropped.
- Reset: c2.mmioRdValid = 0, hdr = 0, data = 0, all stage valids = 0. Reset mid-flight flushes S1 and S2, and no response is issued for flushed requests. The first request is accepted on the cycle after reset deasserts.
- Output contract: c2.mmioRdValid is high for exactly one cycle per accepted request. Outputs are registered with no combinational path from c0 to c2.

Optional Feature:
- HC_MMIO_SCRATCH_EN defined:
  - Adds a 64-bit scratch register at 0x198, reset 0.
  - Written when c0.mmioWrValid is high and address == 0x198>>2. Length 0 writes only the addressed DW.
  - A read issued the cycle after the write returns the new value.
- Not defined: 0x198 reads 0 and mmioWrValid is ignored entirely.

Decomposition:
- Add to reed_solomon_decoder_pkg:
  - Constants HC_DFH, HC_STATUS (16'h180), HC_RD_LINES (16'h188), HC_WR_LINES (16'h190), HC_SCRATCH (16'h198).
  - Typedef t_mmio_rd_req {tid, qword index, length, dw_sel}.
  - Function hc_mmio_rd_sel (returns 1 for mmioRdValid with address < 'h400).
- No sub-module: the read mux stays inline as an always_comb case on the S1 index.

Test Plan:
- Read 0x000 (address 'h0), length 1, tid 'h12 -> two cycles later mmioRdValid = 1, tid 'h12, data 64'h1000_0100_0000_0000.
- Set i_buffer[2].size = 32'hABCD. Read 0x148 with length 0 (address 'h52) -> data 64'h0000_0000_0000_ABCD. Then read address 'h53, length 0 -> data 0.
- Issue three consecutive reads (0x110, 0x118, 0x180) with tids 1, 2, 3 -> three consecutive response cycles, tids 1, 2, 3 in order, data matching inputs.
- Read at DW address 'h400 -> no response. Read 0x0F8 -> response with data 0.
- Issue a read, then assert reset on the next cycle -> no response ever appears. A post-reset read of 0x188 responds normally.
- HC_MMIO_SCRATCH_EN: write 64'hDEAD_BEEF_0123_4567 to 0x198, read it the next cycle -> same value. Without the macro, the same sequence returns 0.

Source files
------------

// File: rtl/hc_mmio_rd_responder_pkg.sv
// hc_mmio_rd_responder_pkg
//   Shared types and constants for the Reed-Solomon AFU MMIO read responder.
//   - Reduced CCI-P c0 Rx / c2 Tx structs. Only the MMIO fields the responder touches are kept.
//   - AFU register byte addresses, plus their qword-index forms used by the read mux.
//   - t_mmio_rd_req: the request state carried in pipeline stage S1.
//   - hc_mmio_rd_sel(): decides whether a c0 beat is a read this block answers.
package hc_mmio_rd_responder_pkg;

  localparam int HC_BUFFER_SIZE = 3;

  // CCI-P MMIO request header: DW address, length code (0 = 4 B, 1 = 8 B), tid.
  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic        rsvd;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [63:0]         data;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  typedef logic [31:0] t_hc_control;

  typedef struct packed {
    logic [63:0] address;
    logic [31:0] size;
  } t_hc_buffer;

  // AFU type, end-of-list
  localparam logic [63:0] HC_DFH = 64'h1000_0100_0000_0000;

  // Register byte addresses
  localparam logic [15:0] HC_DFH_ADDR    = 16'h000;
  localparam logic [15:0] HC_AFU_ID_L    = 16'h008;
  localparam logic [15:0] HC_AFU_ID_H    = 16'h010;
  localparam logic [15:0] HC_DSM_BASE    = 16'h110;
  localparam logic [15:0] HC_CONTROL     = 16'h118;
  localparam logic [15:0] HC_BUFFER_BASE = 16'h120;
  localparam logic [15:0] HC_STATUS      = 16'h180;
  localparam logic [15:0] HC_RD_LINES    = 16'h188;
  localparam logic [15:0] HC_WR_LINES    = 16'h190;
  localparam logic [15:0] HC_SCRATCH     = 16'h198;

  // Qword indices (DW address [15:1] == byte address [15:3])
  localparam logic [14:0] QW_DFH      = 15'(HC_DFH_ADDR >> 3);
  localparam logic [14:0] QW_AFU_ID_L = 15'(HC_AFU_ID_L >> 3);
  localparam logic [14:0] QW_AFU_ID_H = 15'(HC_AFU_ID_H >> 3);
  localparam logic [14:0] QW_DSM_BASE = 15'(HC_DSM_BASE >> 3);
  localparam logic [14:0] QW_CONTROL  = 15'(HC_CONTROL >> 3);
  localparam logic [14:0] QW_BUF_BASE = 15'(HC_BUFFER_BASE >> 3);
  localparam logic [14:0] QW_STATUS   = 15'(HC_STATUS >> 3);
  localparam logic [14:0] QW_RD_LINES = 15'(HC_RD_LINES >> 3);
  localparam logic [14:0] QW_WR_LINES = 15'(HC_WR_LINES >> 3);
  localparam logic [14:0] QW_SCRATCH  = 15'(HC_SCRATCH >> 3);

  // The AFU owns DW addresses below this; above it the host talks to someone else.
  localparam logic [15:0] HC_MMIO_DW_LIMIT = 16'h400;

  typedef struct packed {
    logic [8:0]  tid;
    logic [14:0] qidx;
    logic [1:0]  length;
    logic        dw_sel;
  } t_mmio_rd_req;

  function automatic logic hc_mmio_rd_sel(input t_if_ccip_c0_Rx c0);
    return c0.mmioRdValid && (c0.hdr.address < HC_MMIO_DW_LIMIT);
  endfunction

endpackage

// File: rtl/hc_mmio_rd_responder_if.sv
// hc_mmio_rd_responder_if
//   Bundles the host MMIO request channel (c0 Rx) and the MMIO read response
//   channel (c2 Tx).
//   - master: the host/shim side. Drives c0 and observes c2.
//   - slave:  the AFU responder. Observes c0 and drives c2.
interface hc_mmio_rd_responder_if;
  import hc_mmio_rd_responder_pkg::*;

  t_if_ccip_c0_Rx cp2af_sRx_c0;
  t_if_ccip_c2_Tx af2cp_sTx_c2;

  modport master (output cp2af_sRx_c0, input af2cp_sTx_c2);
  modport slave  (input cp2af_sRx_c0, output af2cp_sTx_c2);
endinterface

// File: rtl/hc_mmio_rd_responder.sv
// hc_mmio_rd_responder
//   CCI-P MMIO read responder for the Reed-Solomon decoder AFU. It answers host
//   reads of the DFH, the AFU ID, the write-side register shadows and the
//   decoder status.
//   The response comes back two cycles after the request, and one request is
//   accepted per cycle.
//   Ports:
//     pClk                 AFU clock
//     pck_cp2af_softReset  synchronous active-high reset
//     mmio (slave)         c0 Rx requests in, c2 Tx read responses out
//     i_dsm_base, i_control, i_buffer[N_BUFFERS]  write-side register shadows
//     i_status, i_rd_lines, i_wr_lines            decoder status / counters
//   Optional build macro: HC_MMIO_SCRATCH_EN. It adds a host-writable 64-bit
//   scratch register at byte address 0x198.
//   N_BUFFERS must be in the range 1..6. Larger values would collide with the
//   status block at 0x180.
module hc_mmio_rd_responder
  import hc_mmio_rd_responder_pkg::*;
#(
  parameter int           N_BUFFERS = HC_BUFFER_SIZE,
  parameter logic [127:0] AFU_ID    = 128'h0
) (
  input  logic                 pClk,
  input  logic                 pck_cp2af_softReset,
  hc_mmio_rd_responder_if.slave mmio,
  input  logic [63:0]          i_dsm_base,
  input  t_hc_control          i_control,
  input  t_hc_buffer           i_buffer [N_BUFFERS],
  input  logic [63:0]          i_status,
  input  logic [31:0]          i_rd_lines,
  input  logic [31:0]          i_wr_lines
);

  t_if_ccip_c0_Rx c0;
  assign c0 = mmio.cp2af_sRx_c0;

  // Only the read and write headers are consumed. The remaining fields are tied off here.
  logic unused_c0;
  assign unused_c0 = ^{c0.hdr.rsvd, c0.data, c0.mmioWrValid};

  // ---------------- S1: latch the decoded request ----------------
  logic         s1_vld_q, s1_vld_d;
  t_mmio_rd_req s1_req_q, s1_req_d;

  always_comb begin
    s1_vld_d        = hc_mmio_rd_sel(c0);
    s1_req_d        = '0;
    s1_req_d.tid    = c0.hdr.tid;
    s1_req_d.qidx   = c0.hdr.address[15:1];
    s1_req_d.length = c0.hdr.length;
    s1_req_d.dw_sel = c0.hdr.address[0];
  end

  // ---------------- optional scratch register ----------------
`ifdef HC_MMIO_SCRATCH_EN
  logic [63:0] scratch_q, scratch_d;

  always_comb begin
    scratch_d = scratch_q;
    if (c0.mmioWrValid && (c0.hdr.address == (HC_SCRATCH >> 2))) begin
      if (c0.hdr.length == 2'd0) scratch_d[31:0] = c0.data[31:0];
      else                       scratch_d       = c0.data;
    end
  end

  always_ff @(posedge pClk) begin
    if (pck_cp2af_softReset) scratch_q <= '0;
    else                     scratch_q <= scratch_d;
  end
`endif

  // ---------------- read mux on the S1 qword index ----------------
  // The i_* inputs are sampled here, one cycle after the request was accepted.
  logic [63:0] rd_qword;

  always_comb begin
    rd_qword = '0;
    case (s1_req_q.qidx)
      QW_DFH:      rd_qword = HC_DFH;
      QW_AFU_ID_L: rd_qword = AFU_ID[63:0];
      QW_AFU_ID_H: rd_qword = AFU_ID[127:64];
      QW_DSM_BASE: rd_qword = i_dsm_base;
      QW_CONTROL:  rd_qword = {32'h0, i_control};
      QW_STATUS:   rd_qword = i_status;
      QW_RD_LINES: rd_qword = {32'h0, i_rd_lines};
      QW_WR_LINES: rd_qword = {32'h0, i_wr_lines};
`ifdef HC_MMIO_SCRATCH_EN
      QW_SCRATCH:  rd_qword = scratch_q;
`endif
      default:     rd_qword = '0;
    endcase
    // Buffer descriptors take two qwords each: the address, then the size.
    for (int k = 0; k < N_BUFFERS; k++) begin
      if (s1_req_q.qidx == QW_BUF_BASE + 15'(2 * k))
        rd_qword = i_buffer[k].address;
      if (s1_req_q.qidx == QW_BUF_BASE + 15'(2 * k + 1))
        rd_qword = {32'h0, i_buffer[k].size};
    end
  end

  // ---------------- S2: registered response ----------------
  t_if_ccip_c2_Tx c2_q, c2_d;

  always_comb begin
    c2_d = '0;
    if (s1_vld_q) begin
      c2_d.mmioRdValid = 1'b1;
      c2_d.hdr.tid     = s1_req_q.tid;
      // A 4 B read returns the selected DW right-justified. Any wider length returns the whole qword.
      if (s1_req_q.length == 2'd0)
        c2_d.data = {32'h0, (s1_req_q.dw_sel ? rd_qword[63:32] : rd_qword[31:0])};
      else
        c2_d.data = rd_qword;
    end
  end

  always_ff @(posedge pClk) begin
    if (pck_cp2af_softReset) begin
      s1_vld_q <= 1'b0;
      s1_req_q <= '0;
      c2_q     <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_req_q <= s1_req_d;
      c2_q     <= c2_d;
    end
  end

  assign mmio.af2cp_sTx_c2 = c2_q;

endmodule

// File: tb/tb_hc_mmio_rd_responder.sv
// tb_hc_mmio_rd_responder
//   Scoreboard bench for hc_mmio_rd_responder.
//   - The driver pushes {tid, data, response cycle} for every read it issues.
//   - The monitor pops on every c2 valid.
//   - Expected data comes from a byte-map model written in plain arithmetic.
module tb_hc_mmio_rd_responder;
  import hc_mmio_rd_responder_pkg::*;

  localparam int          NB     = 3;
  localparam logic [63:0] AFU_LO = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] AFU_HI = 64'h0123_4567_89AB_CDEF;

  logic        pClk = 1'b0;
  logic        pck_cp2af_softReset;
  logic [63:0] i_dsm_base;
  t_hc_control i_control;
  t_hc_buffer  i_buffer [NB];
  logic [63:0] i_status;
  logic [31:0] i_rd_lines;
  logic [31:0] i_wr_lines;

  hc_mmio_rd_responder_if mmio ();

  hc_mmio_rd_responder #(.N_BUFFERS(NB), .AFU_ID({AFU_HI, AFU_LO})) dut (
    .pClk                (pClk),
    .pck_cp2af_softReset (pck_cp2af_softReset),
    .mmio                (mmio),
    .i_dsm_base          (i_dsm_base),
    .i_control           (i_control),
    .i_buffer            (i_buffer),
    .i_status            (i_status),
    .i_rd_lines          (i_rd_lines),
    .i_wr_lines          (i_wr_lines)
  );

  always #5 pClk = ~pClk;

  int cyc = 0;
  always @(posedge pClk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [63:0] scratch_m = 64'h0;

  // ---------------- reference model ----------------
  function automatic logic [63:0] model_rd(input logic [15:0] dw_addr, input logic [1:0] len);
    int b;
    int k;
    logic [63:0] v;
    b = 8 * int'(dw_addr[15:1]);
    v = 64'h0;
    if (b == 'h000)      v = 64'h1000_0100_0000_0000;
    else if (b == 'h008) v = AFU_LO;
    else if (b == 'h010) v = AFU_HI;
    else if (b == 'h110) v = i_dsm_base;
    else if (b == 'h118) v = {32'h0, i_control};
    else if (b == 'h180) v = i_status;
    else if (b == 'h188) v = {32'h0, i_rd_lines};
    else if (b == 'h190) v = {32'h0, i_wr_lines};
    else if (b >= 'h120 && b < 'h120 + 16 * NB) begin
      k = (b - 'h120) / 16;
      v = ((b - 'h120) % 16 == 0) ? i_buffer[k].address : {32'h0, i_buffer[k].size};
    end
`ifdef HC_MMIO_SCRATCH_EN
    if (b == 'h198) v = scratch_m;
`endif
    if (len == 2'd0) v = dw_addr[0] ? {32'h0, v[63:32]} : {32'h0, v[31:0]};
    return v;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge pClk) begin
    if (mmio.af2cp_sTx_c2.mmioRdValid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rsp: cyc %0d tid %h data %h, required no response",
                 cyc, mmio.af2cp_sTx_c2.hdr.tid, mmio.af2cp_sTx_c2.data);
      end else begin
        mon_e = sb.pop_front();
        if (mmio.af2cp_sTx_c2.hdr.tid !== mon_e.tid || mmio.af2cp_sTx_c2.data !== mon_e.data ||
            cyc != mon_e.cyc) begin
          n_fail++;
          $display("FAIL rsp: got cyc %0d tid %h data %h, required cyc %0d tid %h data %h",
                   cyc, mmio.af2cp_sTx_c2.hdr.tid, mmio.af2cp_sTx_c2.data,
                   mon_e.cyc, mon_e.tid, mon_e.data);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_rd(input logic [15:0] a, input logic [1:0] len, input logic [8:0] tid,
                          input bit push);
    t_if_ccip_c0_Rx c;
    exp_t e;
    c = '0;
    c.hdr.address = a;
    c.hdr.length  = len;
    c.hdr.tid     = tid;
    c.mmioRdValid = 1'b1;
    mmio.cp2af_sRx_c0 = c;
    if (push && a < 16'h400) begin
      e.tid  = tid;
      e.data = model_rd(a, len);
      e.cyc  = cyc + 2;
      sb.push_back(e);
    end
  endtask

  task automatic op_rd(input logic [15:0] a, input logic [1:0] len, input logic [8:0] tid,
                       input bit push);
    @(posedge pClk); #1;
    drive_rd(a, len, tid, push);
  endtask

  task automatic op_wr(input logic [15:0] a, input logic [1:0] len, input logic [63:0] d);
    t_if_ccip_c0_Rx c;
    @(posedge pClk); #1;
    c = '0;
    c.hdr.address = a;
    c.hdr.length  = len;
    c.data        = d;
    c.mmioWrValid = 1'b1;
    mmio.cp2af_sRx_c0 = c;
`ifdef HC_MMIO_SCRATCH_EN
    if (a == 16'h66) begin
      if (len == 2'd0) scratch_m[31:0] = d[31:0];
      else             scratch_m       = d;
    end
`endif
  endtask

  task automatic op_idle();
    @(posedge pClk); #1;
    mmio.cp2af_sRx_c0 = '0;
  endtask

  // Waits (bounded) for every expected response, then checks none is missing.
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge pClk);
      n++;
    end
    repeat (3) @(posedge pClk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_idle_out(input string name);
    @(negedge pClk);
    n_checks++;
    if (mmio.af2cp_sTx_c2.mmioRdValid !== 1'b0 || mmio.af2cp_sTx_c2.hdr.tid !== 9'h0 ||
        mmio.af2cp_sTx_c2.data !== 64'h0) begin
      n_fail++;
      $display("FAIL %s: got vld %b tid %h data %h, required all zero", name,
               mmio.af2cp_sTx_c2.mmioRdValid, mmio.af2cp_sTx_c2.hdr.tid, mmio.af2cp_sTx_c2.data);
    end
  endtask

  task automatic randomize_inputs();
    i_dsm_base = {$urandom, $urandom};
    i_control  = $urandom;
    i_status   = {$urandom, $urandom};
    i_rd_lines = $urandom;
    i_wr_lines = $urandom;
    for (int k = 0; k < NB; k++) begin
      i_buffer[k].address = {$urandom, $urandom};
      i_buffer[k].size    = $urandom;
    end
  endtask

  int hot [19] = '{'h000, 'h008, 'h010, 'h018, 'h020, 'h0F8, 'h110, 'h118, 'h120, 'h128,
                   'h130, 'h138, 'h140, 'h148, 'h150, 'h180, 'h188, 'h190, 'h198};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    exp_t e;
    int n;
    pck_cp2af_softReset = 1'b1;
    mmio.cp2af_sRx_c0   = '0;
    randomize_inputs();
    repeat (3) @(posedge pClk);
    check_idle_out("reset_state");
    @(posedge pClk); #1;
    pck_cp2af_softReset = 1'b0;

    // DFH, qword
    op_rd(16'h0, 2'd1, 9'h12, 1'b1);
    op_idle();
    drain();

    // Buffer[2].size lower DW, then its upper DW
    i_buffer[2].size = 32'hABCD;
    op_rd(16'h52, 2'd0, 9'h21, 1'b1);
    op_rd(16'h53, 2'd0, 9'h22, 1'b1);
    op_idle();
    drain();

    // Back-to-back reads: the cycle stamps force consecutive in-order responses
    op_rd(16'h44, 2'd1, 9'h1, 1'b1);
    op_rd(16'h46, 2'd1, 9'h2, 1'b1);
    op_rd(16'h60, 2'd1, 9'h3, 1'b1);
    op_idle();
    drain();

    // Out-of-range read is ignored; unmapped in-range read returns 0
    op_rd(16'h400, 2'd1, 9'h31, 1'b1);
    op_rd(16'h3E, 2'd1, 9'h32, 1'b1);
    op_idle();
    drain();

    // Input sampling point: i_status changes the cycle after the request
    op_rd(16'h60, 2'd1, 9'h7, 1'b0);
    @(posedge pClk); #1;
    mmio.cp2af_sRx_c0 = '0;
    i_status = 64'h0BAD_F00D_0000_0001;
    e.tid = 9'h7; e.data = 64'h0BAD_F00D_0000_0001; e.cyc = cyc + 1;
    sb.push_back(e);
    drain();

    // Reset one cycle after a request flushes it
    op_rd(16'h62, 2'd1, 9'h55, 1'b0);
    @(posedge pClk); #1;
    mmio.cp2af_sRx_c0   = '0;
    pck_cp2af_softReset = 1'b1;
    repeat (2) @(posedge pClk);
    check_idle_out("flush_in_reset");
    @(posedge pClk); #1;
    pck_cp2af_softReset = 1'b0;
    drive_rd(16'h62, 2'd1, 9'h56, 1'b1);   // accepted on the first post-reset cycle
    op_idle();
    drain();

    // Scratch write followed immediately by a read
    op_wr(16'h66, 2'd1, 64'hDEAD_BEEF_0123_4567);
    op_rd(16'h66, 2'd1, 9'h66, 1'b1);
    op_idle();
    drain();

    // Randomized bursts
    for (int b = 0; b < 25; b++) begin
      randomize_inputs();
      n = $urandom_range(4, 16);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 9))
          0: begin
            a = ($urandom_range(0, 1) == 1) ? 16'h66 : 16'($urandom_range(0, 'h3FF));
            op_wr(a, 2'($urandom_range(0, 1)), {$urandom, $urandom});
          end
          1, 2: op_idle();
          default: begin
            if ($urandom_range(0, 9) < 7)
              a = 16'(hot[$urandom_range(0, 18)] / 4 + int'($urandom_range(0, 1)));
            else
              a = 16'($urandom_range(0, 'h47F));
            op_rd(a, 2'($urandom_range(0, 1)), 9'($urandom), 1'b1);
          end
        endcase
      end
      op_idle();
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
